// File: rtl/pipe_stage_chain.sv
// In-order chain of DEPTH valid/ready pipeline registers with per-stage hold and flush.
// Optional performance counters are enabled by defining PIPE_STAGE_CHAIN_PERF_EN.
module pipe_stage_chain #(
  parameter int               WIDTH       = 32,
  parameter int               DEPTH       = 4,
  parameter logic [WIDTH-1:0] BUBBLE_DATA = 32'h00000013,
  parameter int               CNT_W       = $clog2(DEPTH+1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  input  logic                   out_ready,
  input  logic [DEPTH-1:0]       hold_vec,
  input  logic [DEPTH-1:0]       flush_vec,
  output logic [DEPTH-1:0]       stage_valid,
  output logic [DEPTH*WIDTH-1:0] stage_data,
  output logic [CNT_W-1:0]       occupancy
`ifdef PIPE_STAGE_CHAIN_PERF_EN
  ,
  input  logic                   perf_clr,
  output logic [31:0]            perf_stall_cnt,
  output logic [31:0]            perf_bubble_cnt,
  output logic [31:0]            perf_flush_cnt
`endif
);

  function automatic logic [CNT_W-1:0] popcount(input logic [DEPTH-1:0] v);
    logic [CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < DEPTH; i++) cnt = cnt + CNT_W'(v[i]);
    return cnt;
  endfunction

  logic [DEPTH-1:0] vld_p;
  logic [WIDTH-1:0] data_p [DEPTH];
  logic [DEPTH-1:0] send;
  logic [DEPTH-1:0] acc;
  logic [DEPTH-1:0] up_send;
  logic [WIDTH-1:0] up_data [DEPTH];
  logic [DEPTH-1:0] vld_n;
  logic [WIDTH-1:0] data_n [DEPTH];

  assign send = vld_p & ~hold_vec;

  // Upstream view of each stage: stage 0 is fed by the chain input.
  assign up_send[0] = in_valid;
  assign up_data[0] = in_data;
  for (genvar g = 1; g < DEPTH; g++) begin : g_up
    assign up_send[g] = send[g-1];
    assign up_data[g] = data_p[g-1];
  end

  // Accept ripples from the output end back to the input; in_valid never enters it.
  always_comb begin
    logic nxt;
    acc = '0;
    nxt = out_ready;
    for (int i = DEPTH-1; i >= 0; i--) begin
      acc[i] = ~vld_p[i] | (send[i] & nxt) | flush_vec[i];
      nxt    = acc[i];
    end
  end

  always_comb begin
    vld_n  = vld_p;
    data_n = data_p;
    for (int i = 0; i < DEPTH; i++) begin
      if (flush_vec[i]) begin
        vld_n[i]  = 1'b0;
        data_n[i] = BUBBLE_DATA;
      end else if (acc[i] && up_send[i]) begin
        vld_n[i]  = 1'b1;
        data_n[i] = up_data[i];
      end else if (acc[i]) begin
        vld_n[i]  = 1'b0;
        data_n[i] = BUBBLE_DATA;
      end
    end
  end

  // Stage register boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p     <= '0;
      occupancy <= '0;
      for (int i = 0; i < DEPTH; i++) data_p[i] <= BUBBLE_DATA;
    end else begin
      vld_p     <= vld_n;
      occupancy <= popcount(vld_n);
      for (int i = 0; i < DEPTH; i++) data_p[i] <= data_n[i];
    end
  end

  assign in_ready    = acc[0];
  assign out_valid   = send[DEPTH-1];
  assign out_data    = data_p[DEPTH-1];
  assign stage_valid = vld_p;
  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign stage_data[g*WIDTH +: WIDTH] = data_p[g];
  end

`ifdef PIPE_STAGE_CHAIN_PERF_EN
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cnt  <= '0;
      perf_bubble_cnt <= '0;
      perf_flush_cnt  <= '0;
    end else if (perf_clr) begin
      perf_stall_cnt  <= '0;
      perf_bubble_cnt <= '0;
      perf_flush_cnt  <= '0;
    end else begin
      perf_stall_cnt  <= sat_add(perf_stall_cnt, {31'd0, in_valid & ~in_ready});
      perf_bubble_cnt <= sat_add(perf_bubble_cnt, {31'd0, ~out_valid});
      perf_flush_cnt  <= sat_add(perf_flush_cnt, 32'(popcount(vld_p & flush_vec)));
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Self-checking bench for pipe_stage_chain (DEPTH=4, WIDTH=32) using an entry-movement reference model.
module tb_pipe_stage_chain;
  localparam int D = 4;
  localparam int W = 32;
  localparam logic [W-1:0] BUB = 32'h13;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic [W-1:0]   in_data = '0;
  logic           in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           out_ready = 1'b0;
  logic [D-1:0]   hold_vec = '0;
  logic [D-1:0]   flush_vec = '0;
  logic [D-1:0]   stage_valid;
  logic [D*W-1:0] stage_data;
  logic [2:0]     occupancy;
`ifdef PIPE_STAGE_CHAIN_PERF_EN
  logic           perf_clr = 1'b0;
  logic [31:0]    perf_stall_cnt, perf_bubble_cnt, perf_flush_cnt;
`endif

  int checks = 0;
  int errors = 0;

  pipe_stage_chain dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .hold_vec(hold_vec), .flush_vec(flush_vec), .stage_valid(stage_valid),
    .stage_data(stage_data), .occupancy(occupancy)
`ifdef PIPE_STAGE_CHAIN_PERF_EN
    , .perf_clr(perf_clr), .perf_stall_cnt(perf_stall_cnt),
    .perf_bubble_cnt(perf_bubble_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: slots holding entries; entries move forward when the slot ahead frees up.
  logic         m_v [D];
  logic [W-1:0] m_d [D];
  logic         n_v [D];
  logic [W-1:0] n_d [D];
  logic         exp_in_ready, exp_out_valid;
  logic [W-1:0] exp_out_data;
  int           m_occ;

  task automatic model_reset();
    for (int i = 0; i < D; i++) begin m_v[i] = 1'b0; m_d[i] = BUB; end
    m_occ = 0;
  endtask

  task automatic eval();
    logic leaves [D];
    logic free   [D];
    logic ahead_free;
    ahead_free = out_ready;
    for (int i = D-1; i >= 0; i--) begin
      leaves[i]  = m_v[i] && !hold_vec[i] && ahead_free;
      free[i]    = !m_v[i] || leaves[i] || flush_vec[i];
      ahead_free = free[i];
    end
    exp_in_ready  = free[0];
    exp_out_valid = m_v[D-1] && !hold_vec[D-1];
    exp_out_data  = m_d[D-1];
    for (int i = 0; i < D; i++) begin n_v[i] = m_v[i]; n_d[i] = m_d[i]; end
    for (int i = 0; i < D; i++) if (leaves[i]) begin n_v[i] = 1'b0; n_d[i] = BUB; end
    for (int i = 0; i < D-1; i++) if (leaves[i]) begin n_v[i+1] = 1'b1; n_d[i+1] = m_d[i]; end
    if (in_valid && free[0]) begin n_v[0] = 1'b1; n_d[0] = in_data; end
    for (int i = 0; i < D; i++) if (flush_vec[i]) begin n_v[i] = 1'b0; n_d[i] = BUB; end
  endtask

  task automatic step();
    eval();
    @(posedge clk);
    m_occ = 0;
    for (int i = 0; i < D; i++) begin
      m_v[i] = n_v[i]; m_d[i] = n_d[i];
      if (n_v[i]) m_occ++;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; hold_vec = '0; flush_vec = '0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (stage_valid !== 4'b0000) begin errors++; $display("FAIL reset_valid: got %b expected 0000", stage_valid); end
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL reset_occ: got %0d expected 0", occupancy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (stage_data !== {4{BUB}}) begin errors++; $display("FAIL reset_data: got %h expected %h", stage_data, {4{BUB}}); end
  endtask

  task automatic test_streaming();
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      in_data = k;
      step();
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready k=%0d: got %b expected 1", k, in_ready); end
      if (k >= 4) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== W'(k-3)) begin
          errors++; $display("FAIL stream_out k=%0d: got v=%b d=%0d expected v=1 d=%0d", k, out_valid, out_data, k-3);
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [W-1:0] vals [4];
    vals[0] = 32'hA; vals[1] = 32'hB; vals[2] = 32'hC; vals[3] = 32'hD;
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin in_data = vals[k]; step(); end
    in_data = 32'hE;
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (in_ready !== 1'b0 || occupancy !== 3'd4 || out_data !== 32'hA) begin
        errors++; $display("FAIL bp_stall c=%0d: got rdy=%b occ=%0d d=%h expected rdy=0 occ=4 d=a", k, in_ready, occupancy, out_data);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== vals[j]) begin
        errors++; $display("FAIL bp_drain j=%0d: got v=%b d=%h expected v=1 d=%h", j, out_valid, out_data, vals[j]);
      end
      step();
    end
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL bp_empty: got %0d expected 0", occupancy); end
  endtask

  task automatic test_bubble();
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin in_data = 100 + k; step(); end
    hold_vec = 4'b0010; in_data = 103;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bubble_in_ready c=%0d: got %b expected 0", k, in_ready); end
      step();
      checks++;
      if (stage_valid[2] !== 1'b0 || stage_data[2*W +: W] !== BUB) begin
        errors++; $display("FAIL bubble_stage2 c=%0d: got v=%b d=%h expected v=0 d=%h", k, stage_valid[2], stage_data[2*W +: W], BUB);
      end
      checks++;
      if (stage_valid[1] !== 1'b1 || stage_data[1*W +: W] !== 32'd101) begin
        errors++; $display("FAIL bubble_stage1 c=%0d: got v=%b d=%0d expected v=1 d=101", k, stage_valid[1], stage_data[1*W +: W]);
      end
    end
    hold_vec = '0; in_valid = 1'b0;
  endtask

  task automatic test_flush();
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin in_data = 32'h57 + k; step(); end
    flush_vec = 4'b0011; in_data = 32'hDEAD;
    step();
    checks++; if (stage_valid !== 4'b1100) begin errors++; $display("FAIL flush_valid: got %b expected 1100", stage_valid); end
    checks++;
    if (stage_data[0 +: W] !== BUB || stage_data[W +: W] !== BUB) begin
      errors++; $display("FAIL flush_data01: got %h %h expected %h", stage_data[0 +: W], stage_data[W +: W], BUB);
    end
    checks++;
    if (stage_data[3*W +: W] !== 32'h57 || stage_data[2*W +: W] !== 32'h58) begin
      errors++; $display("FAIL flush_keep: got %h %h expected 57 58", stage_data[3*W +: W], stage_data[2*W +: W]);
    end
    flush_vec = 4'b1111; hold_vec = 4'b1111;
    step();
    checks++;
    if (stage_valid !== 4'b0000 || occupancy !== 3'd0) begin
      errors++; $display("FAIL flush_all: got v=%b occ=%0d expected v=0000 occ=0", stage_valid, occupancy);
    end
    flush_vec = '0; hold_vec = '0; in_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin in_data = 200 + k; step(); end
    #2 rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (stage_valid !== 4'b0000 || occupancy !== 3'd0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_mid: got v=%b occ=%0d ov=%b expected 0 0 0", stage_valid, occupancy, out_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %b expected 1", in_ready); end
    in_data = 55;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) step();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'd55) begin
      errors++; $display("FAIL rst_mid_stream: got v=%b d=%0d expected v=1 d=55", out_valid, out_data);
    end
  endtask

  task automatic test_random();
    logic [D*W-1:0] exp_sd;
    logic [D-1:0]   exp_sv;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < D; i++) begin
        hold_vec[i]  = ($urandom_range(0, 7) == 0);
        flush_vec[i] = ($urandom_range(0, 19) == 0);
      end
      #1;
      eval();
      checks++;
      if (in_ready !== exp_in_ready || out_valid !== exp_out_valid || out_data !== exp_out_data) begin
        errors++; $display("FAIL rand_comb c=%0d: got rdy=%b ov=%b od=%h expected rdy=%b ov=%b od=%h",
                           c, in_ready, out_valid, out_data, exp_in_ready, exp_out_valid, exp_out_data);
      end
      step();
      for (int i = 0; i < D; i++) begin exp_sv[i] = m_v[i]; exp_sd[i*W +: W] = m_d[i]; end
      checks++;
      if (stage_valid !== exp_sv || stage_data !== exp_sd || occupancy !== 3'(m_occ)) begin
        errors++; $display("FAIL rand_state c=%0d: got v=%b occ=%0d d=%h expected v=%b occ=%0d d=%h",
                           c, stage_valid, occupancy, stage_data, exp_sv, m_occ, exp_sd);
      end
    end
    in_valid = 1'b0; hold_vec = '0; flush_vec = '0;
  endtask

`ifdef PIPE_STAGE_CHAIN_PERF_EN
  task automatic test_perf();
    do_reset();
    checks++;
    if (perf_stall_cnt !== 0 || perf_bubble_cnt !== 0 || perf_flush_cnt !== 0) begin
      errors++; $display("FAIL perf_reset: got %0d %0d %0d expected 0 0 0", perf_stall_cnt, perf_bubble_cnt, perf_flush_cnt);
    end
    out_ready = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin in_data = k; step(); end
    for (int k = 0; k < 3; k++) step();
    in_valid = 1'b0; flush_vec = 4'b0011;
    step();
    flush_vec = '0;
    checks++;
    if (perf_stall_cnt !== 32'd3 || perf_flush_cnt !== 32'd2 || perf_bubble_cnt !== 32'd4) begin
      errors++; $display("FAIL perf_counts: got s=%0d f=%0d b=%0d expected s=3 f=2 b=4", perf_stall_cnt, perf_flush_cnt, perf_bubble_cnt);
    end
    perf_clr = 1'b1;
    step();
    perf_clr = 1'b0;
    checks++;
    if (perf_stall_cnt !== 0 || perf_bubble_cnt !== 0 || perf_flush_cnt !== 0) begin
      errors++; $display("FAIL perf_clr: got %0d %0d %0d expected 0 0 0", perf_stall_cnt, perf_bubble_cnt, perf_flush_cnt);
    end
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_streaming();
    test_backpressure();
    test_bubble();
    test_flush();
    test_reset_mid();
    test_random();
`ifdef PIPE_STAGE_CHAIN_PERF_EN
    test_perf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
